// File: rtl/udp_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_readout_pkg
// Description : Shared types and constants for the UDP readout packer.
//               - packer state encoding
//               - header magic and header field bit offsets
//               - pkt_len_beats(): header length field for a given burst
// Config      : UDP_PACKER_CHKSUM_EN adds one trailer beat to the length.
// Revision    : 1.0 - initial release
// ============================================================================
package udp_readout_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_TRL  = 2'd3
    } pkt_state_t;

    localparam logic [15:0] c_HDR_MAGIC     = 16'hDA7A;

    // Header beat layout: {magic, seq, timestamp, len}
    localparam int          c_HDR_FIELD_W   = 16;
    localparam int          c_HDR_MAGIC_LSB = 48;
    localparam int          c_HDR_SEQ_LSB   = 32;
    localparam int          c_HDR_TS_LSB    = 16;
    localparam int          c_HDR_LEN_LSB   = 0;

    // Beats following the header: four lanes per DRAM word, plus the
    // checksum trailer when that feature is built in.
    function automatic logic [15:0] pkt_len_beats(input int unsigned words);
`ifdef UDP_PACKER_CHKSUM_EN
        return 16'(words * 4 + 1);
`else
        return 16'(words * 4);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/readout_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : readout_sync_fifo
// Description : Single-clock FIFO for DRAM readout words.
//               - A write becomes visible at the head one cycle later.
//               - A write while full is dropped and sets a sticky overflow
//                 flag, unless a read happens in the same cycle.
//               - o_next peeks the low NEXT_W bits of the entry behind the
//                 head, so the consumer can start the next word
//                 back-to-back with the pop.
// Ports       : clk, rst (sync, active-low)
//               i_wr_en/i_wr_data  push
//               i_rd_en            pop (ignored when empty)
//               o_head, o_next     head word, low bits of next word
//               o_count            occupancy
//               o_full, o_empty, o_overflow
// Revision    : 1.0 - initial release
// ============================================================================
module readout_sync_fifo #(
    parameter int WIDTH  = 256,
    parameter int DEPTH  = 16,
    parameter int NEXT_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_head,
    output logic [NEXT_W-1:0]        o_next,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_overflow
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             r_overflow;
    logic [c_AW-1:0]  w_rd_ptr_nxt;
    logic [WIDTH-1:0] w_next_word;
    logic             w_do_rd;
    logic             w_do_wr;

    assign o_empty      = (r_count == '0);
    assign o_full       = (r_count == (c_AW + 1)'(DEPTH));
    assign w_do_rd      = i_rd_en && !o_empty;
    // A full FIFO still takes the write when the head leaves this cycle.
    assign w_do_wr      = i_wr_en && (!o_full || w_do_rd);
    assign w_rd_ptr_nxt = r_rd_ptr + c_AW'(1);
    assign w_next_word  = r_mem[w_rd_ptr_nxt];

    assign o_head       = r_mem[r_rd_ptr];
    assign o_next       = w_next_word[NEXT_W-1:0];
    assign o_count      = r_count;
    assign o_overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_wr_en && !w_do_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/udp_readout_packer.sv
`default_nettype none
// ============================================================================
// Module      : udp_readout_packer
// Description : Frames DRAM readout bursts into UDP payload beats.
//               A trigger latches its timestamp. The packer then emits a
//               header beat {DA7A, seq, ts, len}, followed by
//               WORDS_PER_PKT*4 payload beats taken lane 0 first from
//               each buffered DRAM word.
// Config      : UDP_PACKER_CHKSUM_EN appends one trailer beat holding the
//               XOR of all payload beats; eop moves to the trailer.
// Ports       : clk, rst (sync, active-low)
//               trig_status, trig_time_stamp   trigger and its timestamp
//               dram_rd_data, dram_rd_valid    DRAM read words
//               tx_data/valid/ready/sop/eop    stream to the MAC
//               fifo_overflow, trig_dropped    sticky error flags
//               busy                           packer not idle
// Revision    : 1.0 - initial release
// ============================================================================
module udp_readout_packer
    import udp_readout_pkg::*;
#(
    parameter int IN_W          = 256,  // must equal 4*OUT_W
    parameter int OUT_W         = 64,
    parameter int FIFO_DEPTH    = 16,
    parameter int WORDS_PER_PKT = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_status,
    input  logic [15:0]      trig_time_stamp,
    input  logic [IN_W-1:0]  dram_rd_data,
    input  logic             dram_rd_valid,
    output logic [OUT_W-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sop,
    output logic             tx_eop,
    output logic             fifo_overflow,
    output logic             trig_dropped,
    output logic             busy
);

    localparam int                  c_LANES         = IN_W / OUT_W;
    localparam int                  c_LANE_W        = $clog2(c_LANES);
    localparam logic [c_LANE_W-1:0] c_LAST_LANE     = c_LANE_W'(c_LANES - 1);
    localparam logic [c_LANE_W-1:0] c_PRE_LAST_LANE = c_LANE_W'(c_LANES - 2);
    localparam int                  c_WC_W          = (WORDS_PER_PKT > 1) ? $clog2(WORDS_PER_PKT) : 1;
    localparam logic [c_WC_W-1:0]   c_LAST_WORD     = c_WC_W'(WORDS_PER_PKT - 1);
    localparam int                  c_CNT_W         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0]         c_HDR_LEN       = pkt_len_beats(WORDS_PER_PKT);
`ifdef UDP_PACKER_CHKSUM_EN
    localparam bit                  c_EOP_ON_PAY    = 1'b0;
`else
    localparam bit                  c_EOP_ON_PAY    = 1'b1;
`endif

    pkt_state_t          r_state;
    logic [OUT_W-1:0]    r_tx_data;
    logic                r_tx_valid;
    logic                r_tx_sop;
    logic                r_tx_eop;
    logic [15:0]         r_seq;
    logic [15:0]         r_ts;
    logic                r_pending;
    logic                r_trig_dropped;
    logic [c_LANE_W-1:0] r_lane;
    logic [c_WC_W-1:0]   r_word_cnt;
`ifdef UDP_PACKER_CHKSUM_EN
    logic [OUT_W-1:0]    r_csum;
`endif

    logic [IN_W-1:0]     w_fifo_head;
    logic [OUT_W-1:0]    w_fifo_next_lo;
    logic [c_CNT_W-1:0]  w_fifo_count;
    logic                w_fifo_empty;
    logic                w_unused_fifo_full;
    logic                w_fifo_rd;
    logic [OUT_W-1:0]    w_head_lane [c_LANES];
    logic [OUT_W-1:0]    w_header;
    logic [c_LANE_W-1:0] w_lane_nxt;
    logic                w_pay_hs;
    logic                w_hdr_acc;
    logic                w_last_word;
    logic                w_last_beat;
    logic                w_fifo_has_next;

    readout_sync_fifo #(
        .WIDTH  (IN_W),
        .DEPTH  (FIFO_DEPTH),
        .NEXT_W (OUT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (dram_rd_valid),
        .i_wr_data  (dram_rd_data),
        .i_rd_en    (w_fifo_rd),
        .o_head     (w_fifo_head),
        .o_next     (w_fifo_next_lo),
        .o_count    (w_fifo_count),
        .o_full     (w_unused_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_overflow (fifo_overflow)
    );

    genvar gi;
    generate
        for (gi = 0; gi < c_LANES; gi++) begin : g_lane
            assign w_head_lane[gi] = w_fifo_head[gi*OUT_W +: OUT_W];
        end
    endgenerate

    always_comb begin
        w_header = '0;
        w_header[c_HDR_MAGIC_LSB +: c_HDR_FIELD_W] = c_HDR_MAGIC;
        w_header[c_HDR_SEQ_LSB   +: c_HDR_FIELD_W] = r_seq;
        w_header[c_HDR_TS_LSB    +: c_HDR_FIELD_W] = r_ts;
        w_header[c_HDR_LEN_LSB   +: c_HDR_FIELD_W] = c_HDR_LEN;
    end

    assign w_hdr_acc       = (r_state == S_HDR) && r_tx_valid && tx_ready;
    assign w_pay_hs        = (r_state == S_PAY) && r_tx_valid && tx_ready;
    assign w_last_word     = (r_word_cnt == c_LAST_WORD);
    assign w_last_beat     = w_last_word && (r_lane == c_LAST_LANE);
    assign w_lane_nxt      = r_lane + c_LANE_W'(1);
    // The head word leaves once its last lane is accepted.
    assign w_fifo_rd       = w_pay_hs && (r_lane == c_LAST_LANE);
    // Occupancy before this edge: a word written now is not yet readable.
    assign w_fifo_has_next = (w_fifo_count > c_CNT_W'(1));

    // Trigger latch. Only one trigger can wait for its header; later ones
    // are discarded and flagged until that header is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending      <= 1'b0;
            r_ts           <= '0;
            r_trig_dropped <= 1'b0;
        end else begin
            if (trig_status) begin
                if (r_pending) begin
                    r_trig_dropped <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                    r_ts      <= trig_time_stamp;
                end
            end
            if (w_hdr_acc) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Framing FSM. r_word_cnt/r_lane name the payload beat currently held
    // in (or waiting for) the output register, and advance on handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
            r_seq      <= '0;
            r_lane     <= '0;
            r_word_cnt <= '0;
`ifdef UDP_PACKER_CHKSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_state    <= S_HDR;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_header;
                        r_tx_sop   <= 1'b1;
                        r_tx_eop   <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (w_hdr_acc) begin
                        r_state    <= S_PAY;
                        r_word_cnt <= '0;
                        r_lane     <= '0;
                        r_tx_sop   <= 1'b0;
                        r_tx_eop   <= 1'b0;
                        r_tx_valid <= !w_fifo_empty;
                        r_tx_data  <= w_head_lane[0];
`ifdef UDP_PACKER_CHKSUM_EN
                        r_csum     <= '0;
`endif
                    end
                end
                S_PAY: begin
                    if (w_pay_hs) begin
`ifdef UDP_PACKER_CHKSUM_EN
                        r_csum <= r_csum ^ r_tx_data;
`endif
                        if (w_last_beat) begin
                            r_seq <= r_seq + 16'd1;
`ifdef UDP_PACKER_CHKSUM_EN
                            // Trailer includes the beat accepted this edge.
                            r_state    <= S_TRL;
                            r_tx_data  <= r_csum ^ r_tx_data;
                            r_tx_eop   <= 1'b1;
`else
                            r_state    <= S_IDLE;
                            r_tx_valid <= 1'b0;
                            r_tx_eop   <= 1'b0;
`endif
                        end else if (r_lane == c_LAST_LANE) begin
                            // Next word starts without a bubble if present.
                            r_lane     <= '0;
                            r_word_cnt <= r_word_cnt + c_WC_W'(1);
                            r_tx_valid <= w_fifo_has_next;
                            r_tx_data  <= w_fifo_next_lo;
                            r_tx_eop   <= 1'b0;
                        end else begin
                            r_lane     <= w_lane_nxt;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= w_head_lane[w_lane_nxt];
                            r_tx_eop   <= c_EOP_ON_PAY && w_last_word &&
                                          (r_lane == c_PRE_LAST_LANE);
                        end
                    end else if (!r_tx_valid && !w_fifo_empty) begin
                        // Underrun recovery: present the waiting beat.
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_head_lane[r_lane];
                        r_tx_eop   <= c_EOP_ON_PAY && w_last_beat;
                    end
                end
`ifdef UDP_PACKER_CHKSUM_EN
                S_TRL: begin
                    if (r_tx_valid && tx_ready) begin
                        r_state    <= S_IDLE;
                        r_tx_valid <= 1'b0;
                        r_tx_eop   <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                    r_tx_sop   <= 1'b0;
                    r_tx_eop   <= 1'b0;
                end
            endcase
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign tx_sop       = r_tx_sop;
    assign tx_eop       = r_tx_eop;
    assign trig_dropped = r_trig_dropped;
    assign busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_udp_readout_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_udp_readout_packer
// Description : Self-checking bench for udp_readout_packer. Expected packets
//               are built from the DRAM words handed to the DUT: header
//               {DA7A, seq, ts, len}, then four 64-bit lanes per word with
//               lane 0 first. UDP_PACKER_CHKSUM_EN adds an XOR trailer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_readout_packer;

    localparam int WPP = 11;
`ifdef UDP_PACKER_CHKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         trig_status = 1'b0;
    logic [15:0]  trig_time_stamp = '0;
    logic [255:0] dram_rd_data = '0;
    logic         dram_rd_valid = 1'b0;
    logic [63:0]  tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b0;
    logic         tx_sop;
    logic         tx_eop;
    logic         fifo_overflow;
    logic         trig_dropped;
    logic         busy;

    always #5 clk = ~clk;

    udp_readout_packer #(
        .IN_W(256), .OUT_W(64), .FIFO_DEPTH(16), .WORDS_PER_PKT(WPP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .trig_status     (trig_status),
        .trig_time_stamp (trig_time_stamp),
        .dram_rd_data    (dram_rd_data),
        .dram_rd_valid   (dram_rd_valid),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .tx_sop          (tx_sop),
        .tx_eop          (tx_eop),
        .fifo_overflow   (fifo_overflow),
        .trig_dropped    (trig_dropped),
        .busy            (busy)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t        got[$];
    beat_t        exp_q[$];
    logic [255:0] feed_q[$];
    logic [255:0] words[$];
    logic [255:0] ov_words[$];
    int           checks = 0;
    int           errors = 0;
    int           ready_pct = 100;
    int           feed_mode = 0;
    int           cyc = 0;
    bit           trig_req = 1'b0;
    logic [15:0]  trig_ts_req = '0;
    bit           prev_stall = 1'b0;
    logic [65:0]  prev_out = '0;
    logic [15:0]  ts_a;
    logic [15:0]  ts_b;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic gen_words(input int n);
        words.delete();
        repeat (n) words.push_back(rnd_word());
    endtask

    // Reference packet built straight from the framing rules.
    task automatic build_exp(input logic [15:0] seq, input logic [15:0] ts,
                             input logic [255:0] w[$]);
        logic [63:0]  x;
        logic [63:0]  b;
        logic [255:0] word;
        logic [15:0]  len;
        x   = '0;
        len = 16'(w.size() * 4 + (CHK ? 1 : 0));
        exp_q.delete();
        exp_q.push_back('{d: {16'hDA7A, seq, ts, len}, sop: 1'b1, eop: 1'b0});
        foreach (w[i]) begin
            word = w[i];
            for (int l = 0; l < 4; l++) begin
                b = word[64*l +: 64];
                x = x ^ b;
                exp_q.push_back('{d: b, sop: 1'b0,
                                  eop: 1'(!CHK && (i == w.size() - 1) && (l == 3))});
            end
        end
        if (CHK) exp_q.push_back('{d: x, sop: 1'b0, eop: 1'b1});
    endtask

    // One clock: entered and left at a negedge. Checks stall stability,
    // drives this cycle's inputs, and records the handshake at the edge.
    task automatic cycle();
        bit do_feed;
        if (prev_stall)
            chk("stall_hold", {tx_valid, tx_sop, tx_eop, tx_data}, {1'b1, prev_out});
        trig_status     = trig_req;
        trig_time_stamp = trig_req ? trig_ts_req : 16'($urandom);
        trig_req        = 1'b0;
        case (feed_mode)
            0:       do_feed = 1'b1;
            1:       do_feed = (cyc % 2 == 0);
            default: do_feed = ($urandom_range(99) < 60);
        endcase
        if (do_feed && feed_q.size() > 0) begin
            dram_rd_valid = 1'b1;
            dram_rd_data  = feed_q.pop_front();
        end else begin
            dram_rd_valid = 1'b0;
            dram_rd_data  = rnd_word();
        end
        tx_ready = ($urandom_range(99) < ready_pct);
        if (rst && tx_valid && tx_ready)
            got.push_back('{d: tx_data, sop: tx_sop, eop: tx_eop});
        prev_stall = rst && tx_valid && !tx_ready;
        prev_out   = {tx_sop, tx_eop, tx_data};
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic fire(input logic [15:0] ts);
        trig_req    = 1'b1;
        trig_ts_req = ts;
        cycle();
    endtask

    task automatic run_until(input int n, input int budget);
        int c;
        c = 0;
        while (got.size() < n && c < budget) begin
            cycle();
            c++;
        end
        repeat (8) cycle();
    endtask

    task automatic check_pkt(input string tag);
        chk({tag, " beat_count"}, 80'(got.size()), 80'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), 80'(got[i]), 80'(exp_q[i]));
        got.delete();
    endtask

    initial begin
        @(negedge clk);
        repeat (3) cycle();
        chk("reset_flags", {tx_valid, tx_sop, tx_eop, busy, fifo_overflow, trig_dropped}, '0);
        chk("reset_data", tx_data, '0);
        rst = 1'b1;
        cycle();

        // T1: beats 1..44 with tx_ready high, plus trigger-to-header latency.
        words.delete();
        for (int i = 0; i < WPP; i++) begin
            logic [255:0] w;
            for (int l = 0; l < 4; l++) w[64*l +: 64] = 64'(4*i + l + 1);
            words.push_back(w);
        end
        fire(16'h1234);
        chk("hdr_not_yet", {tx_valid, busy}, 2'b00);
        feed_q = words;
        cycle();
        chk("hdr_latency", {tx_valid, tx_sop, busy}, 3'b111);
        build_exp(16'd0, 16'h1234, words);
        run_until(exp_q.size(), 500);
        if (got.size() > 0)
            chk("t1_header_const", got[0].d, CHK ? 64'hDA7A_0000_1234_002D : 64'hDA7A_0000_1234_002C);
        check_pkt("t1");

        // T2: 50% backpressure, same framing, seq now 1.
        ready_pct = 50;
        ts_a = 16'($urandom);
        gen_words(WPP);
        fire(ts_a);
        feed_q = words;
        build_exp(16'd1, ts_a, words);
        run_until(exp_q.size(), 1500);
        check_pkt("t2");

        // T3: header stalled 40 cycles while 20 words arrive.
        ready_pct = 0;
        feed_mode = 1;
        ts_a = 16'($urandom);
        gen_words(20);
        ov_words = words;
        fire(ts_a);
        feed_q = words;
        repeat (40) cycle();
        chk("ovf_set", fifo_overflow, 1'b1);
        chk("ovf_hdr_stalled", {tx_valid, tx_sop, busy}, 3'b111);
        ready_pct = 100;
        feed_mode = 0;
        words.delete();
        for (int i = 0; i < WPP; i++) words.push_back(ov_words[i]);
        build_exp(16'd2, ts_a, words);
        run_until(exp_q.size(), 500);
        check_pkt("t3");
        // Words 11..15 remain buffered; 16..19 were lost.
        words.delete();
        for (int i = WPP; i < 16; i++) words.push_back(ov_words[i]);
        ts_a = 16'($urandom);
        fire(ts_a);
        for (int i = 0; i < WPP - 5; i++) begin
            logic [255:0] w;
            w = rnd_word();
            words.push_back(w);
            feed_q.push_back(w);
        end
        build_exp(16'd3, ts_a, words);
        run_until(exp_q.size(), 500);
        check_pkt("t3_rest");

        // T4: second trigger while the first is pending.
        chk("drop_clear", {trig_dropped, fifo_overflow}, 2'b01);
        ts_a = 16'($urandom);
        ts_b = ~ts_a;
        fire(ts_a);
        fire(ts_b);
        chk("drop_set", trig_dropped, 1'b1);
        gen_words(WPP);
        feed_q = words;
        build_exp(16'd4, ts_a, words);
        run_until(exp_q.size(), 500);
        repeat (20) cycle();
        check_pkt("t4_one_header");

        // T5: one-cycle reset in the middle of the payload.
        ts_a = 16'($urandom);
        fire(ts_a);
        gen_words(WPP);
        feed_q = words;
        begin
            int c;
            c = 0;
            while (got.size() < 10 && c < 200) begin
                cycle();
                c++;
            end
        end
        chk("t5_reached_payload", 80'(got.size() >= 10), 80'(1));
        rst = 1'b0;
        feed_q.delete();
        cycle();
        rst = 1'b1;
        chk("midrst_flags", {tx_valid, tx_sop, tx_eop, busy, fifo_overflow, trig_dropped}, '0);
        chk("midrst_data", tx_data, '0);
        got.delete();
        ts_a = 16'($urandom);
        fire(ts_a);
        gen_words(WPP);
        feed_q = words;
        build_exp(16'd0, ts_a, words);
        run_until(exp_q.size(), 500);
        check_pkt("t5_after_rst");

        // T6: random feed gaps (underrun bubbles) and random backpressure.
        ready_pct = 50;
        feed_mode = 2;
        for (int p = 0; p < 3; p++) begin
            ts_a = 16'($urandom);
            fire(ts_a);
            gen_words(WPP);
            feed_q = words;
            build_exp(16'(p + 1), ts_a, words);
            run_until(exp_q.size(), 2000);
            check_pkt($sformatf("t6_pkt%0d", p));
        end
        chk("t6_no_flags", {fifo_overflow, trig_dropped}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
